// File: rtl/mem_intf_mux_if.sv
// mem_intf: req/gnt request channel plus r_valid/r_ready
// read response channel between an initiator and a target.
interface mem_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;

    modport master (
        output req, addr, wen, data, be, r_ready,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, addr, wen, data, be, r_ready,
        output gnt, r_valid, r_data
    );
endinterface

// File: rtl/mem_intf_mux.sv
// mem_intf_mux: round-robin N-to-1 mux for mem_intf with
// stall locking and a single outstanding routed read.
module mem_intf_mux #(
    parameter int NR_INPUTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input logic     clk_i,
    input logic     resetn_i,
    mem_intf.slave  master_ports [NR_INPUTS],
    mem_intf.master slave_port
);
    localparam int SEL_WIDTH = $clog2(NR_INPUTS);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t               state_q;
    logic [SEL_WIDTH-1:0] rr_q;
    logic [SEL_WIDTH-1:0] lock_idx_q;
    logic [SEL_WIDTH-1:0] active_q;
    logic                 lock_q;

    logic [NR_INPUTS-1:0]  req_vec;
    logic [NR_INPUTS-1:0]  wen_vec;
    logic [NR_INPUTS-1:0]  rdy_vec;
    logic [NR_INPUTS-1:0]  gnt_vec;
    logic [ADDR_WIDTH-1:0] addr_arr [NR_INPUTS];
    logic [DATA_WIDTH-1:0] data_arr [NR_INPUTS];
    logic [BE_WIDTH-1:0]   be_arr   [NR_INPUTS];

    logic [SEL_WIDTH-1:0] sel;
    logic                 found;
    logic                 pending;
    logic                 rsp_done;
    logic                 issue;
    logic                 fwd;
    logic                 granted;

    function automatic logic [SEL_WIDTH-1:0] wrap_idx(
        input logic [SEL_WIDTH-1:0] base,
        input int                   off
    );
        int s;
        s = int'(base) + off;
        if (s >= NR_INPUTS) s = s - NR_INPUTS;
        return SEL_WIDTH'(s);
    endfunction

    assign pending = resetn_i && (state_q == PENDING);

    generate
        for (genvar i = 0; i < NR_INPUTS; i++) begin : g_port
            logic mine;
            assign mine        = pending && (active_q == SEL_WIDTH'(i));
            assign req_vec[i]  = master_ports[i].req;
            assign wen_vec[i]  = master_ports[i].wen;
            assign rdy_vec[i]  = master_ports[i].r_ready;
            assign addr_arr[i] = master_ports[i].addr;
            assign data_arr[i] = master_ports[i].data;
            assign be_arr[i]   = master_ports[i].be;
            assign master_ports[i].gnt     = gnt_vec[i];
            assign master_ports[i].r_valid = mine && slave_port.r_valid;
            assign master_ports[i].r_data  =
                mine ? slave_port.r_data : '0;
        end
    endgenerate

    // Descending scan so the first requester after rr_q wins.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        if (lock_q) begin
            sel   = lock_idx_q;
            found = req_vec[lock_idx_q];
        end else begin
            for (int j = NR_INPUTS - 1; j >= 0; j--) begin
                if (req_vec[wrap_idx(rr_q, j)]) begin
                    sel   = wrap_idx(rr_q, j);
                    found = 1'b1;
                end
            end
        end
    end

    assign rsp_done = pending && slave_port.r_valid
                    && rdy_vec[active_q];
    assign issue    = resetn_i
                    && ((state_q == IDLE) || rsp_done);
    assign fwd      = issue && found;
    assign granted  = fwd && slave_port.gnt;

    always_comb begin
        gnt_vec = '0;
        if (granted) gnt_vec[sel] = 1'b1;
    end

    assign slave_port.req     = fwd;
    assign slave_port.wen     = fwd ? wen_vec[sel]  : 1'b1;
    assign slave_port.addr    = fwd ? addr_arr[sel] : '0;
    assign slave_port.data    = fwd ? data_arr[sel] : '0;
    assign slave_port.be      = fwd ? be_arr[sel]   : '0;
    assign slave_port.r_ready = pending && rdy_vec[active_q];

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            active_q   <= '0;
        end else begin
            if (fwd && !slave_port.gnt) begin
                lock_q     <= 1'b1;
                lock_idx_q <= sel;
            end else if (granted) begin
                lock_q <= 1'b0;
            end
            if (granted) begin
                rr_q <= (sel == SEL_WIDTH'(NR_INPUTS - 1))
                      ? '0 : sel + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (granted && !wen_vec[sel]) begin
                        active_q <= sel;
                        state_q  <= PENDING;
                    end
                end
                PENDING: begin
                    if (rsp_done) begin
                        if (granted && !wen_vec[sel]) begin
                            active_q <= sel;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The target must never answer when no read is outstanding.
    assert property (@(posedge clk_i) disable iff (!resetn_i)
        !((state_q == IDLE) && slave_port.r_valid))
        else $error("unsolicited r_valid while idle");
endmodule
